// File: rtl/i2s_quad_rx.sv
// i2s_quad_rx: four-line I2S master receiver. Generates a shared sck/ws pair,
// deserialises the left-channel word of every sd line in lockstep and hands the
// words out as one CH*DW bundle over a valid/ready handshake.
// Optional feature: define I2S_QUAD_RX_OVF_CNT_EN to add the 8-bit saturating
// ovf_cnt output that counts overrun pulses.
module i2s_quad_rx #(
  parameter int DW          = 16,
  parameter int CH          = 4,
  parameter int WARM_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [7:0]         sck_period,
  output logic               sck,
  output logic               ws,
  input  logic [CH-1:0]      sd,
  output logic [CH*DW-1:0]   dout,
  output logic               dout_vld,
  input  logic               dout_rdy,
  output logic               overrun
`ifdef I2S_QUAD_RX_OVF_CNT_EN
  ,
  output logic [7:0]         ovf_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    RUN
  } state_t;

  state_t state, state_nxt;

  logic [7:0]                period_q;
  logic [7:0]                div_q;
  logic [4:0]                slot_q;
  logic [3:0]                frame_q;
  logic [CH-1:0][DW-1:0]     shreg;
  logic                      load_pend;

  logic                      div_wrap;
  logic                      rise_tgl;
  logic                      fall_tgl;
  logic                      word_done;
  logic [4:0]                slot_nxt;

  // Decode the divider wrap into sck rising/falling toggles and spot the
  // rising toggle of slot 16, which carries the LSB of the left word.
  always_comb begin
    div_wrap  = (state != IDLE) && (div_q == period_q - 8'd1);
    rise_tgl  = div_wrap && !sck;
    fall_tgl  = div_wrap && sck;
    slot_nxt  = slot_q + 5'd1;
    word_done = rise_tgl && (slot_q == 5'd16);
  end

  // Next-state logic: en low always wins; warm-up ends once the discarded
  // frames have all delivered their left word.
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = WARM;
        WARM:    if (word_done && (frame_q == 4'(WARM_FRAMES - 1))) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Bit-clock generator: divider, sck/ws toggling, slot and warm-up frame
  // counting. The half-period is captured only when leaving IDLE so that
  // sck_period changes while running have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= 8'd2;
      div_q    <= '0;
      slot_q   <= '0;
      frame_q  <= '0;
      sck      <= 1'b0;
      ws       <= 1'b0;
    end else if (!en || (state == IDLE)) begin
      div_q    <= '0;
      slot_q   <= '0;
      frame_q  <= '0;
      sck      <= 1'b0;
      ws       <= 1'b0;
      if (en) period_q <= (sck_period < 8'd2) ? 8'd2 : sck_period;
    end else begin
      if (div_wrap) begin
        div_q <= '0;
        sck   <= ~sck;
      end else begin
        div_q <= div_q + 8'd1;
      end
      if (fall_tgl) begin
        slot_q <= slot_nxt;
        ws     <= slot_nxt[4];
      end
      if (word_done && (state == WARM)) frame_q <= frame_q + 4'd1;
    end
  end

  // Per-line shift registers: only slots 1..16 carry left-channel bits
  // (one-bit I2S delay), so slot 0 and the right-channel slots are skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (en && (state == IDLE)) begin
      shreg <= '0;
    end else if (en && rise_tgl && (slot_q >= 5'd1) && (slot_q <= 5'd16)) begin
      for (int i = 0; i < CH; i++) shreg[i] <= {shreg[i][DW-2:0], sd[i]};
    end
  end

  // Output handshake: a completed word in RUN arms load_pend, and the bundle
  // is loaded one cycle later. Loading over an unaccepted bundle flags an
  // overrun; a load coinciding with a transfer keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout      <= '0;
      dout_vld  <= 1'b0;
      overrun   <= 1'b0;
      load_pend <= 1'b0;
    end else if (!en || (state == IDLE)) begin
      dout_vld  <= 1'b0;
      overrun   <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      load_pend <= word_done && (state == RUN);
      overrun   <= 1'b0;
      if (load_pend) begin
        dout     <= shreg;
        dout_vld <= 1'b1;
        overrun  <= dout_vld && !dout_rdy;
      end else if (dout_vld && dout_rdy) begin
        dout_vld <= 1'b0;
      end
    end
  end

`ifdef I2S_QUAD_RX_OVF_CNT_EN
  // Saturating overrun counter; survives en toggling and clears only on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             ovf_cnt <= '0;
    else if (overrun && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_quad_rx.sv
// tb_i2s_quad_rx: self-checking bench for i2s_quad_rx. A slave transmitter
// model plays per-frame words onto sd; expected bundles and timing come from
// the frame table and plain frame/slot arithmetic.
// Optional feature: define I2S_QUAD_RX_OVF_CNT_EN to also check ovf_cnt.
module tb_i2s_quad_rx;

  localparam int DW = 16;
  localparam int CH = 4;
  localparam int WF = 2;

  logic               clk        = 1'b0;
  logic               rst        = 1'b1;
  logic               en         = 1'b0;
  logic [7:0]         sck_period = 8'd4;
  logic [CH-1:0]      sd         = '0;
  logic               dout_rdy   = 1'b0;
  logic               sck;
  logic               ws;
  logic               dout_vld;
  logic               overrun;
  logic [CH*DW-1:0]   dout;
`ifdef I2S_QUAD_RX_OVF_CNT_EN
  logic [7:0]         ovf_cnt;
`endif

  int checks   = 0;
  int passes   = 0;
  int fails    = 0;
  int cyc      = 0;
  int e0       = 0;
  int tx_gen   = 0;
  int tx_seen  = 0;
  int tx_slot  = 0;
  int tx_frame = 0;

  logic [DW-1:0] words [64][CH];

  i2s_quad_rx #(.DW(DW), .CH(CH), .WARM_FRAMES(WF)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sck_period (sck_period),
    .sck        (sck),
    .ws         (ws),
    .sd         (sd),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .dout_rdy   (dout_rdy),
    .overrun    (overrun)
`ifdef I2S_QUAD_RX_OVF_CNT_EN
    ,
    .ovf_cnt    (ovf_cnt)
`endif
  );

  // System clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Free-running count of rising clk edges, used as the timing reference.
  always @(posedge clk) cyc <= cyc + 1;

  // Slave transmitter: follows the master sck, drives the MSB in slot 1 and
  // the LSB in slot 16, junk in the right-channel slots. A new tx_gen
  // resynchronises it to slot 0 of frame 0 at the first falling edge.
  always @(negedge sck) begin
    if (tx_seen != tx_gen) begin
      tx_seen  = tx_gen;
      tx_slot  = 0;
      tx_frame = 0;
    end
    tx_slot = (tx_slot + 1) % 32;
    if (tx_slot == 0) tx_frame = tx_frame + 1;
    for (int c = 0; c < CH; c++)
      sd[c] = (tx_slot >= 1 && tx_slot <= 16) ?
              words[6'(tx_frame)][2'(c)][4'(16 - tx_slot)] : 1'($urandom);
  end

  // Hang guard in case some wait never completes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference bundle for a given frame index since enable.
  function automatic logic [63:0] expBundle(input int f);
    logic [63:0] b;
    b = '0;
    for (int c = 0; c < CH; c++) b[c*DW +: DW] = words[6'(f)][2'(c)];
    return b;
  endfunction

  // Drop en, refill the frame table, then enable with a new sck_period.
  // e0 is the cycle count seen just after the edge that samples en high.
  task automatic applyStimulus(input logic [7:0] period, input bit fixedHead);
    logic [DW-1:0] fv [CH];
    fv[0] = 16'h1234;
    fv[1] = 16'h8001;
    fv[2] = 16'hFFFF;
    fv[3] = 16'h7FFE;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    for (int f = 0; f < 64; f++)
      for (int c = 0; c < CH; c++)
        words[6'(f)][2'(c)] = (fixedHead && f <= WF) ? fv[2'(c)] : DW'($urandom);
    sck_period = period;
    tx_gen++;
    en = 1'b1;
    @(negedge clk);
    e0 = cyc;
  endtask

  // Wait (bounded) for dout_vld; n is cycles since e0, or -1 on timeout.
  task automatic waitVld(input int bound, output int n);
    n = -1;
    for (int i = 0; i < bound; i++) begin
      if (dout_vld === 1'b1) begin
        n = cyc - e0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Measure the sck period in clk cycles between two rising edges.
  task automatic measureSck(output int per);
    int   t0;
    logic prev;
    per  = -1;
    t0   = -1;
    prev = sck;
    for (int i = 0; i < 2000 && per < 0; i++) begin
      @(negedge clk);
      if (sck && !prev) begin
        if (t0 < 0) t0 = cyc;
        else        per = cyc - t0;
      end
      prev = sck;
    end
  endtask

  // Directed sequence of scenarios.
  initial begin
    int n;
    int prevN;
    int bad;
    int ovrCount;
    int target;
    int lEdge;
    bit found;

    $display("[TB] i2s_quad_rx bench starting");

    // Reset values, then a long idle stretch with en low.
    repeat (3) @(negedge clk);
    checkOutput("rst_sck", 64'(sck), 64'd0);
    checkOutput("rst_ws", 64'(ws), 64'd0);
    checkOutput("rst_vld", 64'(dout_vld), 64'd0);
    checkOutput("rst_dout", dout, 64'd0);
    checkOutput("rst_overrun", 64'(overrun), 64'd0);
`ifdef I2S_QUAD_RX_OVF_CNT_EN
    checkOutput("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (sck !== 1'b0 || ws !== 1'b0 || dout_vld !== 1'b0 || dout !== '0) bad++;
    end
    checkOutput("idle_1000", 64'(bad), 64'd0);

    // P=4 with fixed words: first-valid latency, contents, bundle spacing.
    dout_rdy = 1'b1;
    applyStimulus(8'd4, 1'b1);
    waitVld(2000, n);
    checkOutput("first_vld_lat_p4", 64'(n), 64'(WF*64*4 + 33*4 + 1));
    checkOutput("first_bundle_p4", dout, 64'h7FFE_FFFF_8001_1234);
    @(negedge clk);
    checkOutput("vld_drop_after_xfer", 64'(dout_vld), 64'd0);
    prevN = n;
    for (int f = WF + 1; f <= WF + 3; f++) begin
      waitVld(1000, n);
      checkOutput("bundle_spacing_p4", 64'(n - prevN), 64'd256);
      checkOutput("bundle_data_p4", dout, expBundle(f));
      prevN = n;
      @(negedge clk);
    end

    // sck_period=0 behaves as P=2; later changes while running are ignored.
    dout_rdy = 1'b0;
    applyStimulus(8'd0, 1'b0);
    waitVld(2000, n);
    checkOutput("first_vld_lat_p2", 64'(n), 64'(WF*64*2 + 33*2 + 1));
    checkOutput("first_bundle_p2", dout, expBundle(WF));
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ws !== 1'(tx_slot >= 16)) bad++;
    end
    checkOutput("ws_vs_slot", 64'(bad), 64'd0);
    measureSck(n);
    checkOutput("sck_period_p0", 64'(n), 64'd4);
    sck_period = 8'd9;
    measureSck(n);
    checkOutput("sck_period_change_ignored", 64'(n), 64'd4);

    // Asynchronous reset while a bundle is pending.
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    #1;
    checkOutput("async_rst_sck", 64'(sck), 64'd0);
    checkOutput("async_rst_ws", 64'(ws), 64'd0);
    checkOutput("async_rst_vld", 64'(dout_vld), 64'd0);
    checkOutput("async_rst_dout", dout, 64'd0);
    checkOutput("async_rst_overrun", 64'(overrun), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Consumer stalled: one overrun per extra load, newest bundle kept.
    applyStimulus(8'd2, 1'b0);
    waitVld(2000, n);
    checkOutput("stall_first_bundle", dout, expBundle(WF));
    ovrCount = 0;
    target   = e0 + 128*(WF + 1) + 67 + 3;
    while (cyc < target) begin
      @(negedge clk);
      if (overrun === 1'b1) ovrCount++;
    end
    checkOutput("overrun_once", 64'(ovrCount), 64'd1);
    checkOutput("overrun_newest_bundle", dout, expBundle(WF + 1));
    checkOutput("overrun_vld_held", 64'(dout_vld), 64'd1);
`ifdef I2S_QUAD_RX_OVF_CNT_EN
    checkOutput("ovf_cnt_one", 64'(ovf_cnt), 64'd1);
`endif
    target = e0 + 128*(WF + 300) + 67 + 3;
    while (cyc < target) begin
      @(negedge clk);
      if (overrun === 1'b1) ovrCount++;
    end
    checkOutput("overrun_count_300", 64'(ovrCount), 64'd300);
    checkOutput("overrun_bundle_300", dout, expBundle(WF + 300));
`ifdef I2S_QUAD_RX_OVF_CNT_EN
    checkOutput("ovf_cnt_saturated", 64'(ovf_cnt), 64'd255);
`endif

    // Ready rises exactly in the load cycle: old transfers, new stays valid.
    lEdge = e0 + 128*(WF + 301) + 67;
    while (cyc < lEdge - 1) @(negedge clk);
    checkOutput("pending_vld_before_load", 64'(dout_vld), 64'd1);
    checkOutput("pending_old_bundle", dout, expBundle(WF + 300));
    dout_rdy = 1'b1;
    @(negedge clk);
    checkOutput("load_xfer_vld", 64'(dout_vld), 64'd1);
    checkOutput("load_xfer_new_bundle", dout, expBundle(WF + 301));
    checkOutput("load_xfer_no_overrun", 64'(overrun), 64'd0);
    @(negedge clk);
    checkOutput("load_xfer_vld_drop", 64'(dout_vld), 64'd0);
    checkOutput("load_xfer_no_overrun_late", 64'(overrun), 64'd0);

    // en dropped at slot 10: partial word discarded, warm-up restarts.
    applyStimulus(8'd4, 1'b0);
    waitVld(2000, n);
    checkOutput("reenable_base_lat", 64'(n), 64'(WF*64*4 + 33*4 + 1));
    checkOutput("reenable_base_bundle", dout, expBundle(WF));
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (tx_frame == WF + 1 && tx_slot == 10) found = 1'b1;
    end
    checkOutput("reached_slot10", 64'(found), 64'd1);
    en = 1'b0;
    @(negedge clk);
    checkOutput("drop_sck_low", 64'(sck), 64'd0);
    checkOutput("drop_ws_low", 64'(ws), 64'd0);
    checkOutput("drop_vld_low", 64'(dout_vld), 64'd0);
    bad = 0;
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      if (dout_vld !== 1'b0) bad++;
    end
    checkOutput("no_vld_partial_frame", 64'(bad), 64'd0);
    applyStimulus(8'd4, 1'b1);
    waitVld(2000, n);
    checkOutput("reenable_lat", 64'(n), 64'(WF*64*4 + 33*4 + 1));
    checkOutput("reenable_bundle", dout, 64'h7FFE_FFFF_8001_1234);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/i2s_quad_rx.md
# i2s_quad_rx

Four-channel I2S master receiver. It generates one shared bit clock (`sck`) and word select (`ws`) for the error, reference, audio and step-size microphones/sources. It deserialises the left-channel word of all four data lines in lockstep and presents them as one 64-bit sample bundle over a single valid/ready handshake. It sits directly upstream of the ANC core's input merge, replacing per-channel receivers plus the external valid merge.

## Interface

Parameters:
- `DW`, 16: bits per channel word.
- `CH`, 4: number of data lines; bit `i` of `sd` maps to `dout[i*DW +: DW]`.
- `WARM_FRAMES`, 2: complete frames discarded after enable before the first valid bundle (1..15).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: run enable (driven by init-done); low forces IDLE.
- `sck_period`, in, 8: sck half-period in `clk` cycles; values 0 and 1 are treated as 2; latched on the IDLE->WARM transition.
- `sck`, out, 1: I2S bit clock.
- `ws`, out, 1: I2S word select; 0 = left.
- `sd`, in, CH: serial data lines.
- `dout`, out, CH*DW: sample bundle, two's complement, MSB first on the wire.
- `dout_vld`, out, 1: bundle valid.
- `dout_rdy`, in, 1: consumer ready.
- `overrun`, out, 1: one-cycle pulse when an unconsumed bundle is overwritten.
- `ovf_cnt`, out, 8: saturating overrun count; present only with `I2S_QUAD_RX_OVF_CNT_EN`.

## Operation

- States: IDLE, WARM, RUN.
  - IDLE -> WARM when `en`=1. On this transition: latch P = max(`sck_period`, 2) and clear div, slot, frame counters and shift registers.
  - WARM -> RUN after `WARM_FRAMES` frames complete.
  - Any state -> IDLE when `en`=0. In IDLE: `sck`=0, `ws`=0, `dout_vld` cleared, `dout` held.
- Clock generation:
  - div counter runs 0..P-1; at wrap, `sck` toggles.
  - On each `sck` falling toggle, slot increments modulo 32, and `ws` <= (next slot >= 16).
  - Slot 0 begins with `sck`=0 at state entry.
- Sampling:
  - On each `sck` rising toggle, every `sd[i]` is shifted into its shift register, but only in slots 1..16 (I2S one-bit delay): MSB at slot 1, LSB at slot 16.
  - Right-channel slots (17..31, 0) are ignored.
- Bundle complete: occurs at the rising toggle of slot 16. In WARM it only advances the frame counter. In RUN it loads `dout` from the shift registers.
- Handshake:
  - A transfer occurs on any cycle with `dout_vld` & `dout_rdy`.
  - `dout` is stable while `dout_vld`=1 and no new load occurs.
  - `dout_vld` falls the cycle after a transfer unless a load occurs in that same cycle.
- Overrun (load while `dout_vld`=1 and `dout_rdy`=0): `dout` takes the newest bundle, `dout_vld` stays 1, `overrun` pulses for 1 cycle.
- Load and transfer in the same cycle: the old bundle transfers, the new bundle loads, `dout_vld` stays 1, no overrun.
- `sck_period` changes outside IDLE are ignored until the next enable.

## Timing

- Reset values: `sck`=0, `ws`=0, `dout`=0, `dout_vld`=0, `overrun`=0, `ovf_cnt`=0, state IDLE.
- `sck` period is 2P clk cycles; a frame is 32 slots = 64P clk cycles; `ws` edges coincide with `sck` falling toggles.
- A bundle load happens 33P clk cycles after frame start (the rising edge of slot 16). `dout_vld` goes high the following cycle (1-cycle latency).
- First `dout_vld` after enable: WARM_FRAMES*64P + 33P + 1 cycles after the `en`-high edge is sampled.
- `en` dropped mid-frame: the next cycle is IDLE, the partial word is discarded, and no valid is produced.
- `rst` mid-operation: all outputs are immediately at their reset values.

## Configuration

- `I2S_QUAD_RX_OVF_CNT_EN` defined:
  - `ovf_cnt` port and an 8-bit counter exist.
  - The counter increments on each `overrun` pulse and saturates at 255.
  - It is cleared only by `rst`, not by `en`.
- Not defined: no `ovf_cnt` port and no counter; the `overrun` pulse is unchanged.

## Test plan

- Reset, `en`=0 -> `sck`=`ws`=`dout_vld`=0 and `dout`=0 for 1000 cycles.
- P=4, WARM_FRAMES=2, `sd` lines drive 0x1234, 0x8001, 0xFFFF, 0x7FFE in the left slot; `dout_rdy`=1 -> first `dout_vld` at cycle 645 after enable with `dout`={0x7FFE,0xFFFF,0x8001,0x1234}; a new bundle every 256 cycles.
- `sck_period`=0 -> `sck` period is 4 clk cycles; `sck_period` changed to 9 mid-RUN -> period is unchanged.
- `dout_rdy`=0 across two bundle loads -> `overrun` pulses once, `dout` holds the second bundle, `ovf_cnt`=1 (macro on); 300 forced overruns -> `ovf_cnt`=255.
- `dout_rdy` rises in exactly the load cycle -> old bundle accepted, new bundle valid next cycle, no `overrun`.
- `en` dropped at slot 10, re-raised 50 cycles later -> no valid from the partial frame; WARM is restarted; first valid at the same latency as the initial enable.
